// File: rtl/fft_out_unloader_pkg.sv
// rtl/fft_out_unloader_pkg.sv - shared FFT sample type, frame size and bit-reverse helper
package fft_out_unloader_pkg;

  localparam int FFT_N  = 8;
  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] r;
    logic signed [CPLX_W-1:0] i;
  } complex_product_t;

  // Reverses the low nbits of idx; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] v;
    logic [31:0] r;
    v = idx;
    r = '0;
    for (int b = 0; b < nbits; b++) begin
      r = {r[30:0], v[0]};
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one N-entry frame register bank, whole-frame write, indexed read
module fft_frame_bank
  import fft_out_unloader_pkg::*;
#(
  parameter int  N  = FFT_N,
  localparam int IW = $clog2(N)
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  complex_product_t [N-1:0]  wdata_i,
  input  logic [IW-1:0]             raddr_i,
  output complex_product_t          rdata_o
);

  complex_product_t [N-1:0] mem_q;

  // Frame storage is deliberately left unreset; validity lives in the owner's full flags.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_out_unloader.sv
// rtl/fft_out_unloader.sv - ping-pong capture of parallel FFT frames, streamed out one sample per cycle
module fft_out_unloader
  import fft_out_unloader_pkg::*;
#(
  parameter int N           = FFT_N,
  parameter bit BIT_REVERSE = 1'b0,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  complex_product_t [N-1:0]  frame_in,
  input  logic                      frame_valid,
  output complex_product_t          sample_out,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic [$clog2(N)-1:0]      sample_idx,
  output logic                      sample_last,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count
);

  localparam int IW = $clog2(N);

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       full_q, full_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic             xfer, last_xfer, accept, drop;
  logic [1:0]       bank_we;
  logic [IW-1:0]    rd_addr;
  complex_product_t bank_rdata [2];

  assign xfer      = full_q[rd_sel_q] && sample_ready;
  assign last_xfer = xfer && (rd_idx_q == IW'(N - 1));
  // A bank being released by its final transfer this cycle may be refilled in the same cycle.
  assign accept    = frame_valid && (!full_q[wr_sel_q] || (last_xfer && (rd_sel_q == wr_sel_q)));
  assign drop      = frame_valid && !accept;
  assign bank_we   = accept ? (2'b01 << wr_sel_q) : 2'b00;
  assign rd_addr   = BIT_REVERSE ? IW'(bitrev(32'(rd_idx_q), IW)) : rd_idx_q;

  always_comb begin
    full_d       = full_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    rd_idx_d     = rd_idx_q;
    overflow_d   = drop;
    drop_count_d = drop_count_q;
    if (xfer) begin
      rd_idx_d = rd_idx_q + 1'b1;
      if (last_xfer) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        rd_idx_d         = '0;
      end
    end
    if (accept) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (drop && (drop_count_q != {CNT_W{1'b1}})) drop_count_d = drop_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      full_q       <= 2'b00;
      rd_idx_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      full_q       <= full_d;
      rd_idx_q     <= rd_idx_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N)) u_bank (
      .clk_i   (clk),
      .we_i    (bank_we[b]),
      .wdata_i (frame_in),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  assign sample_valid = full_q[rd_sel_q];
  assign sample_out   = sample_valid ? bank_rdata[rd_sel_q] : '0;
  assign sample_idx   = rd_idx_q;
  assign sample_last  = sample_valid && (rd_idx_q == IW'(N - 1));
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_fft_out_unloader.sv
// tb/tb_fft_out_unloader.sv - scoreboard bench for fft_out_unloader, natural and bit-reversed instances
module tb_fft_out_unloader;
  import fft_out_unloader_pkg::*;

  localparam int N = FFT_N;

  typedef struct {
    complex_product_t d;
    int               idx;
    logic             last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  complex_product_t [N-1:0] frame_in = '0;
  logic                     frame_valid = 1'b0;
  logic                     sample_ready = 1'b0;

  complex_product_t s_out   [2];
  logic             s_valid [2];
  logic [2:0]       s_idx   [2];
  logic             s_last  [2];
  logic             s_ovf   [2];
  logic [7:0]       s_dc    [2];

  int tests = 0;
  int fails = 0;

  exp_t                     sbq [2][$];
  complex_product_t [N-1:0] held [$];
  int                       cons = 0;
  int                       m_drops = 0;
  logic                     m_ovf = 1'b0;

  always #5 clk = ~clk;

  fft_out_unloader #(.N(N), .BIT_REVERSE(1'b0), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .sample_out(s_out[0]), .sample_valid(s_valid[0]), .sample_ready(sample_ready),
    .sample_idx(s_idx[0]), .sample_last(s_last[0]), .overflow(s_ovf[0]), .drop_count(s_dc[0])
  );

  fft_out_unloader #(.N(N), .BIT_REVERSE(1'b1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .sample_out(s_out[1]), .sample_valid(s_valid[1]), .sample_ready(sample_ready),
    .sample_idx(s_idx[1]), .sample_last(s_last[1]), .overflow(s_ovf[1]), .drop_count(s_dc[1])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: two-frame FIFO of whole frames; a frame is dropped only when two are held
  // and the oldest is not handing over its final sample on this edge.
  always @(posedge clk or negedge reset) begin : model
    bit xfer, rel, acc;
    int src;
    exp_t e;
    if (!reset) begin
      held.delete();
      sbq[0].delete();
      sbq[1].delete();
      cons    = 0;
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      xfer  = (held.size() > 0) && sample_ready;
      rel   = xfer && (cons == N - 1);
      acc   = frame_valid && ((held.size() < 2) || rel);
      m_ovf = frame_valid && !acc;
      if (m_ovf && m_drops < 255) m_drops++;
      if (xfer) cons++;
      if (rel) begin
        void'(held.pop_front());
        cons = 0;
      end
      if (acc) begin
        held.push_back(frame_in);
        for (int u = 0; u < 2; u++) begin
          for (int j = 0; j < N; j++) begin
            src    = (u == 1) ? int'(bitrev(32'(j), $clog2(N))) : j;
            e.d    = frame_in[src];
            e.idx  = j;
            e.last = (j == N - 1);
            sbq[u].push_back(e);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    for (int u = 0; u < 2; u++) begin
      check($sformatf("valid[%0d]", u), 64'(s_valid[u]), 64'(sbq[u].size() > 0));
      if (sbq[u].size() > 0) begin
        check($sformatf("data[%0d]", u), 64'(s_out[u]), 64'(sbq[u][0].d));
        check($sformatf("idx[%0d]", u), 64'(s_idx[u]), 64'(sbq[u][0].idx));
        check($sformatf("last[%0d]", u), 64'(s_last[u]), 64'(sbq[u][0].last));
        if (s_valid[u] && sample_ready) void'(sbq[u].pop_front());
      end else begin
        check($sformatf("idle_data[%0d]", u), 64'(s_out[u]), 64'd0);
        check($sformatf("idle_last[%0d]", u), 64'(s_last[u]), 64'd0);
      end
      check($sformatf("overflow[%0d]", u), 64'(s_ovf[u]), 64'(m_ovf));
      check($sformatf("drop_count[%0d]", u), 64'(s_dc[u]), 64'(m_drops));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input complex_product_t [N-1:0] f);
    frame_in    = f;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
  endtask

  function automatic complex_product_t [N-1:0] rand_frame();
    complex_product_t [N-1:0] f;
    for (int k = 0; k < N; k++) begin
      f[k].r = CPLX_W'($urandom);
      f[k].i = CPLX_W'($urandom);
    end
    return f;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    complex_product_t [N-1:0] ramp;
    int ord [8];
    ord = '{1, 5, 3, 7, 2, 6, 4, 8};
    for (int k = 0; k < N; k++) begin
      ramp[k].r = CPLX_W'(k + 1);
      ramp[k].i = CPLX_W'(-(k + 1));
    end

    step(3);
    check("rst_valid", 64'(s_valid[0]), 64'd0);
    check("rst_data",  64'(s_out[0]),   64'd0);
    check("rst_idx",   64'(s_idx[0]),   64'd0);
    check("rst_last",  64'(s_last[0]),  64'd0);
    check("rst_ovf",   64'(s_ovf[0]),   64'd0);
    check("rst_dc",    64'(s_dc[0]),    64'd0);
    reset = 1'b1;
    step(2);

    sample_ready = 1'b1;
    send(ramp);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("ramp_nat",  64'(s_out[0]),   64'(ramp[k]));
      check("ramp_brev", 64'(s_out[1].r), 64'(ord[k]));
      check("ramp_last", 64'(s_last[0]),  64'(k == N - 1));
    end
    step(4);

    send(rand_frame());
    send(rand_frame());
    step(20);

    sample_ready = 1'b0;
    send(rand_frame());
    send(rand_frame());
    send(rand_frame());
    step(3);
    check("drop_one", 64'(s_dc[0]), 64'd1);
    sample_ready = 1'b1;
    step(20);

    sample_ready = 1'b0;
    repeat (300) send(rand_frame());
    step(2);
    check("drop_sat", 64'(s_dc[0]), 64'd255);
    sample_ready = 1'b1;
    step(20);

    sample_ready = 1'b0;
    send(rand_frame());
    send(rand_frame());
    step(2);
    sample_ready = 1'b1;
    step(7);
    send(rand_frame());
    step(30);

    repeat (400) begin
      sample_ready = 1'($urandom_range(0, 1));
      frame_in     = rand_frame();
      frame_valid  = ($urandom_range(0, 3) == 0);
      step();
    end
    frame_valid  = 1'b0;
    sample_ready = 1'b1;
    step(30);

    send(rand_frame());
    step(3);
    #1;
    reset = 1'b0;
    #1;
    check("async_valid0", 64'(s_valid[0]), 64'd0);
    check("async_valid1", 64'(s_valid[1]), 64'd0);
    check("async_idx",    64'(s_idx[0]),   64'd0);
    check("async_dc",     64'(s_dc[0]),    64'd0);
    step(2);
    reset = 1'b1;
    step();
    send(ramp);
    step(15);

    check("sb_empty0", 64'(sbq[0].size()), 64'd0);
    check("sb_empty1", 64'(sbq[1].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
